// File: rtl/hls_handshake_loop_monitor.sv
// Passive observer for an HLS ap_* handshake and one pipelined loop inside it.
// It keeps saturating statistics counters and freezes them when finish is raised.
module hls_handshake_loop_monitor #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               mod_start,
  input  logic               mod_ready,
  input  logic               mod_done,
  input  logic               mod_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic [CNT_W-1:0]   mod_stall_cycles,
  output logic [CNT_W-1:0]   loop_iter_start_cnt,
  output logic [CNT_W-1:0]   loop_iter_end_cnt,
  output logic [CNT_W-1:0]   loop_inflight,
  output logic [CNT_W-1:0]   loop_run_cnt,
  output logic               frozen,
  output logic               overflow
);
  localparam int NCNT = 7;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic mstart, mdone, stall, istart, iend, lquit, qhit, hold;
  logic inf_up, inf_dn, inf_sat, underflow, busy_n;
  logic [NCNT-1:0] inc, sat;
  logic [NCNT-1:0][CNT_W-1:0] cnt;

  // loop_start/loop_ready are part of the observed bundle but carry no statistic
  logic unused_in;
  assign unused_in = loop_start ^ loop_ready;

  assign mstart = mod_start & mod_ready;
  assign mdone  = mod_done & mod_continue;
  assign stall  = mod_done & ~mod_continue;
  assign istart = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
  assign iend   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
  assign qhit   = (cur_state == quit_state) & quit_enable & ~quit_block;
  assign lquit  = loop_done & loop_continue & (quit_at_end ? qhit : 1'b1);
  assign hold   = frozen | finish;

  // a new start in the same cycle as done keeps the transaction open
  assign busy_n = mod_start | (mod_busy & ~mdone);

  assign inc = {lquit, iend, istart, stall, mod_busy, mdone, mstart};

  always_comb begin
    sat = '0;
    for (int i = 0; i < NCNT; i++) sat[i] = inc[i] & (cnt[i] == MAX);
  end

  assign inf_up    = istart & ~iend;
  assign inf_dn    = iend & ~istart;
  assign inf_sat   = inf_up & (loop_inflight == MAX);
  assign underflow = inf_dn & (loop_inflight == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt           <= '0;
      loop_inflight <= '0;
      mod_busy      <= 1'b0;
      frozen        <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (finish) frozen <= 1'b1;
      if (!hold) begin
        for (int i = 0; i < NCNT; i++)
          if (inc[i] && !sat[i]) cnt[i] <= cnt[i] + 1'b1;
        if (inf_up && !inf_sat) loop_inflight <= loop_inflight + 1'b1;
        else if (inf_dn && !underflow) loop_inflight <= loop_inflight - 1'b1;
        if ((|sat) || inf_sat || underflow) overflow <= 1'b1;
        mod_busy <= busy_n;
      end
    end
  end

  assign mod_start_cnt       = cnt[0];
  assign mod_done_cnt        = cnt[1];
  assign mod_busy_cycles     = cnt[2];
  assign mod_stall_cycles    = cnt[3];
  assign loop_iter_start_cnt = cnt[4];
  assign loop_iter_end_cnt   = cnt[5];
  assign loop_run_cnt        = cnt[6];
endmodule

// File: tb/tb_hls_handshake_loop_monitor.sv
// Directed bench for hls_handshake_loop_monitor: handshake vector table plus
// hand-written loop, freeze, saturation and underflow sequences (CNT_W=4).
module tb_hls_handshake_loop_monitor;
  localparam int CW = 4;

  logic clock = 1'b0, reset, finish;
  logic mod_start, mod_ready, mod_done, mod_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
  logic mod_busy, frozen, overflow;
  logic [CW-1:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_stall_cycles;
  logic [CW-1:0] loop_iter_start_cnt, loop_iter_end_cnt, loop_inflight, loop_run_cnt;

  int checks = 0, failures = 0;

  hls_handshake_loop_monitor #(.STATE_W(1), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done),
    .mod_continue(mod_continue), .cur_state(cur_state),
    .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .quit_state(quit_state), .iter_start_block(iter_start_block),
    .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready),
    .loop_done(loop_done), .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
    .mod_busy_cycles(mod_busy_cycles), .mod_stall_cycles(mod_stall_cycles),
    .loop_iter_start_cnt(loop_iter_start_cnt), .loop_iter_end_cnt(loop_iter_end_cnt),
    .loop_inflight(loop_inflight), .loop_run_cnt(loop_run_cnt),
    .frozen(frozen), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic st, rd, dn, ct;
    logic busy;
    int   s, d, b, stl;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    finish = 0; mod_start = 0; mod_ready = 0; mod_done = 0; mod_continue = 1;
    cur_state = 1'b1; iter_start_state = 1'b1; iter_end_state = 1'b1; quit_state = 1'b1;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 0; idle(); tick(); tick(); reset = 1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".busy"}, int'(mod_busy), 0);
    chk({tag, ".start_cnt"}, int'(mod_start_cnt), 0);
    chk({tag, ".done_cnt"}, int'(mod_done_cnt), 0);
    chk({tag, ".busy_cyc"}, int'(mod_busy_cycles), 0);
    chk({tag, ".stall"}, int'(mod_stall_cycles), 0);
    chk({tag, ".istart"}, int'(loop_iter_start_cnt), 0);
    chk({tag, ".iend"}, int'(loop_iter_end_cnt), 0);
    chk({tag, ".inflight"}, int'(loop_inflight), 0);
    chk({tag, ".run"}, int'(loop_run_cnt), 0);
    chk({tag, ".frozen"}, int'(frozen), 0);
    chk({tag, ".overflow"}, int'(overflow), 0);
  endtask

  initial begin
    int issued, retired, peak, cyc;
    logic prev_st, blk, se;

    //          st rd dn ct busy s  d  b   stl
    tbl[0]  = '{1, 1, 0, 1, 1,   1, 0, 0,  0};
    tbl[1]  = '{0, 0, 0, 1, 1,   1, 0, 1,  0};
    tbl[2]  = '{0, 0, 0, 1, 1,   1, 0, 2,  0};
    tbl[3]  = '{0, 0, 0, 1, 1,   1, 0, 3,  0};
    tbl[4]  = '{0, 0, 0, 1, 1,   1, 0, 4,  0};
    tbl[5]  = '{0, 0, 1, 1, 0,   1, 1, 5,  0};
    tbl[6]  = '{0, 0, 0, 1, 0,   1, 1, 5,  0};
    tbl[7]  = '{1, 1, 0, 1, 1,   2, 1, 5,  0};
    tbl[8]  = '{0, 0, 1, 0, 1,   2, 1, 6,  1};
    tbl[9]  = '{0, 0, 1, 0, 1,   2, 1, 7,  2};
    tbl[10] = '{0, 0, 1, 0, 1,   2, 1, 8,  3};
    tbl[11] = '{0, 0, 1, 0, 1,   2, 1, 9,  4};
    tbl[12] = '{0, 0, 1, 1, 0,   2, 2, 10, 4};
    tbl[13] = '{1, 1, 0, 1, 1,   3, 2, 10, 4};
    tbl[14] = '{1, 1, 1, 1, 1,   4, 3, 11, 4};
    tbl[15] = '{0, 0, 1, 1, 0,   4, 4, 12, 4};
    tbl[16] = '{1, 0, 0, 1, 1,   4, 4, 12, 4};
    tbl[17] = '{1, 1, 0, 1, 1,   5, 4, 13, 4};
    tbl[18] = '{0, 0, 1, 1, 0,   5, 5, 14, 4};

    // reset held with random input activity
    idle(); reset = 0;
    for (int i = 0; i < 3; i++) begin
      {mod_start, mod_ready, mod_done, mod_continue} = 4'($urandom);
      {iter_start_enable, iter_end_enable, loop_done, loop_continue, finish} = 5'($urandom);
      tick();
      check_zero($sformatf("rst%0d", i));
    end
    reset = 1; idle();

    // module handshake table
    for (int i = 0; i < 19; i++) begin
      mod_start = tbl[i].st; mod_ready = tbl[i].rd;
      mod_done = tbl[i].dn; mod_continue = tbl[i].ct;
      if (i == 0) begin
        #1 chk("no_comb_path", int'(mod_start_cnt), 0);
      end
      tick();
      chk($sformatf("v%0d.busy", i), int'(mod_busy), int'(tbl[i].busy));
      chk($sformatf("v%0d.start", i), int'(mod_start_cnt), tbl[i].s);
      chk($sformatf("v%0d.done", i), int'(mod_done_cnt), tbl[i].d);
      chk($sformatf("v%0d.busycyc", i), int'(mod_busy_cycles), tbl[i].b);
      chk($sformatf("v%0d.stall", i), int'(mod_stall_cycles), tbl[i].stl);
    end
    idle();
    chk("tbl.overflow", int'(overflow), 0);

    // loop: wrong state is not an iteration event
    do_reset();
    cur_state = 1'b0; iter_start_enable = 1; iter_end_enable = 1; tick();
    chk("state_miss.istart", int'(loop_iter_start_cnt), 0);
    chk("state_miss.iend", int'(loop_iter_end_cnt), 0);
    idle();

    // 10 iterations, depth 2, start stage blocked for 2 cycles
    issued = 0; retired = 0; peak = 0; prev_st = 0; cyc = 0;
    while (retired < 10 && cyc < 40) begin
      blk = (cyc == 3 || cyc == 4);
      se = (issued < 10);
      iter_start_enable = se; iter_start_block = blk; iter_end_enable = prev_st;
      if (se && !blk) issued++;
      if (prev_st) retired++;
      prev_st = se && !blk;
      tick();
      chk($sformatf("loop%0d.inflight", cyc), int'(loop_inflight), issued - retired);
      if (int'(loop_inflight) > peak) peak = int'(loop_inflight);
      cyc++;
    end
    idle();
    chk("loop.bound", int'(retired == 10), 1);
    chk("loop.istart", int'(loop_iter_start_cnt), 10);
    chk("loop.iend", int'(loop_iter_end_cnt), 10);
    chk("loop.final_inflight", int'(loop_inflight), 0);
    chk("loop.peak_ok", int'(peak >= 1 && peak <= 2), 1);
    chk("loop.run_before", int'(loop_run_cnt), 0);

    loop_done = 1; loop_continue = 0; tick();
    chk("quit.nocont", int'(loop_run_cnt), 0);
    loop_continue = 1; tick();
    chk("quit.run1", int'(loop_run_cnt), 1);
    quit_at_end = 1; quit_enable = 1; quit_block = 1; tick();
    chk("quit.blocked", int'(loop_run_cnt), 1);
    quit_block = 0; tick();
    chk("quit.end_stage", int'(loop_run_cnt), 2);
    idle();

    // freeze mid-loop; finish-cycle events are dropped
    iter_start_enable = 1; tick();
    chk("frz.pre_istart", int'(loop_iter_start_cnt), 11);
    chk("frz.pre_inflight", int'(loop_inflight), 1);
    finish = 1; iter_end_enable = 1; mod_start = 1; mod_ready = 1; tick();
    chk("frz.frozen", int'(frozen), 1);
    chk("frz.istart_edge", int'(loop_iter_start_cnt), 11);
    chk("frz.start_edge", int'(mod_start_cnt), 0);
    finish = 0; loop_done = 1; loop_continue = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("frz.frozen_hold", int'(frozen), 1);
    chk("frz.istart", int'(loop_iter_start_cnt), 11);
    chk("frz.iend", int'(loop_iter_end_cnt), 10);
    chk("frz.inflight", int'(loop_inflight), 1);
    chk("frz.run", int'(loop_run_cnt), 2);
    chk("frz.mstart", int'(mod_start_cnt), 0);
    chk("frz.busy", int'(mod_busy), 0);
    do_reset();
    check_zero("rst_after_freeze");

    // saturation: 17 accepted starts into a 4-bit counter
    mod_start = 1; mod_ready = 1;
    for (int i = 0; i < 17; i++) tick();
    idle();
    chk("sat.start", int'(mod_start_cnt), 15);
    chk("sat.busycyc", int'(mod_busy_cycles), 15);
    chk("sat.overflow", int'(overflow), 1);

    // inflight underflow
    do_reset();
    chk("unf.pre_overflow", int'(overflow), 0);
    iter_end_enable = 1; tick(); idle();
    chk("unf.inflight", int'(loop_inflight), 0);
    chk("unf.iend", int'(loop_iter_end_cnt), 1);
    chk("unf.overflow", int'(overflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
